// File: rtl/siso_branch_metric.sv
// ---------------------------------------------------------------------------
// siso_branch_metric
//
// Branch-metric front end of the max-log-MAP SISO decoder. The serial LLR
// stream arrives as alternating systematic / parity words on `in`. This block
// pairs them up and matches each pair with one a-priori LLR taken in order
// from a small FIFO. For every symbol it emits two saturated branch metrics:
//   g1 = sys + apr + par
//   g2 = sys + apr - par
// It also tracks the position of each symbol within its block and flags the
// final symbol.
//
// Optional feature macro: SISO_BM_TAIL_EN
//   When defined, each block of `len` info symbols is followed by 3 tail
//   symbols. Tail symbols use apr = 0 and do not consume a-priori samples, and
//   last_out marks the final tail symbol. When undefined, a block is exactly
//   `len` symbols and last_out marks symbol len-1.
//
// Parameters
//   IN_W       width of signed channel / a-priori LLRs
//   OUT_W      width of signed branch metrics (IN_W+2 is lossless)
//   APR_DEPTH  a-priori FIFO depth, power of two, >= 2
//   BLK_W      width of blklen and of the symbol counter
//
// Ports
//   clk             clock, all logic on the rising edge
//   rst             synchronous active-high reset
//   in              serial LLR word (sys, par, sys, par, ...)
//   valid_in        qualifies in
//   apriori         a-priori LLR of the info bit
//   valid_apriori   qualifies apriori
//   blklen          info symbols per block, sampled on the first sys of a block
//   init_branch1_t  g1, registered, held between symbols
//   init_branch2_t  g2, registered, held between symbols
//   valid_out       one-cycle pulse per emitted symbol
//   last_out        with valid_out: final symbol of the block
//   sym_idx         0-based index of the emitted symbol within its block
//   err             sticky: [0] a-priori overflow, [1] pair overrun,
//                   [2] blklen == 0
// ---------------------------------------------------------------------------
module siso_branch_metric #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 18,
  parameter int APR_DEPTH = 4,
  parameter int BLK_W     = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in,
  input  logic             valid_in,
  input  logic [IN_W-1:0]  apriori,
  input  logic             valid_apriori,
  input  logic [BLK_W-1:0] blklen,
  output logic [OUT_W-1:0] init_branch1_t,
  output logic [OUT_W-1:0] init_branch2_t,
  output logic             valid_out,
  output logic             last_out,
  output logic [BLK_W-1:0] sym_idx,
  output logic [2:0]       err
);

  localparam int AW    = (APR_DEPTH > 1) ? $clog2(APR_DEPTH) : 1;
  localparam int SUM_W = IN_W + 2;
  // Sums are formed one bit wider than both the lossless sum and the output,
  // so the saturation compare can never itself overflow.
  localparam int CMP_W = ((OUT_W > SUM_W) ? OUT_W : SUM_W) + 1;

  localparam logic signed [CMP_W-1:0] SAT_MAX =
    {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] SAT_MIN = -SAT_MAX;
  localparam logic [AW:0] DEPTH = (AW+1)'(APR_DEPTH);

  typedef enum logic {
    EXP_SYS,
    EXP_PAR
  } pair_state_t;

  pair_state_t state_q, state_d;

  logic [IN_W-1:0]  sys_q;
  logic [IN_W-1:0]  par_q;
  logic             pair_rdy_q;

  logic [IN_W-1:0]  apr_mem [APR_DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      apr_cnt_q;

  logic [BLK_W-1:0] sym_cnt_q;
  logic [BLK_W-1:0] len_q;

  logic fifo_full, fifo_nempty, apr_ready;
  logic in_tail, sym_last;
  logic accept, overrun, par_done, fire_held, fire;
  logic push, pop, apr_ovf, new_block;

  logic signed [CMP_W-1:0] sys_x, par_x, apr_x, g1_x, g2_x;

  function automatic logic signed [CMP_W-1:0] sext(input logic [IN_W-1:0] x);
    return {{(CMP_W-IN_W){x[IN_W-1]}}, x};
  endfunction

  // Symmetric clamp: the most-negative output code is never produced.
  function automatic logic [OUT_W-1:0] sat(input logic signed [CMP_W-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[OUT_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    return v[OUT_W-1:0];
  endfunction

  assign fifo_full   = (apr_cnt_q == DEPTH);
  assign fifo_nempty = (apr_cnt_q != '0);

  // Tail symbols follow the info symbols of a block; they need no a-priori
  // sample, so they may fire as soon as their pair is complete.
`ifdef SISO_BM_TAIL_EN
  assign in_tail  = (sym_cnt_q >= len_q);
  assign sym_last = (sym_cnt_q == len_q + BLK_W'(2));
`else
  assign in_tail  = 1'b0;
  assign sym_last = (sym_cnt_q == len_q - BLK_W'(1));
`endif

  assign apr_ready = in_tail || fifo_nempty;
  assign fire_held = pair_rdy_q && apr_ready;
  assign par_done  = accept && (state_q == EXP_PAR);
  // A pair completing this cycle can fire immediately, so a par word and the
  // a-priori pop may coincide. pair_rdy_q and par_done are exclusive because
  // the FSM is back in EXP_SYS whenever a pair is held.
  assign fire      = (pair_rdy_q || par_done) && apr_ready;
  assign pop       = fire && !in_tail;
  assign push      = valid_apriori && (!fifo_full || pop);
  assign apr_ovf   = valid_apriori && fifo_full && !pop;

  // A sys word starts a new block when every earlier symbol has fired and the
  // counter is back at zero, or when the held pair firing alongside it closes
  // the previous block.
  assign new_block = accept && (state_q == EXP_SYS) &&
                     (fire ? sym_last : (sym_cnt_q == '0));

  assign sys_x = sext(sys_q);
  assign par_x = sext(pair_rdy_q ? par_q : in);
  assign apr_x = in_tail ? '0 : sext(apr_mem[rd_ptr_q]);
  assign g1_x  = sys_x + apr_x + par_x;
  assign g2_x  = sys_x + apr_x - par_x;

  // Pairing FSM next state. A word that arrives while a completed pair is
  // still waiting for its a-priori sample is an overrun: it is dropped and the
  // FSM holds. If the held pair fires in that same cycle, the word is taken.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    overrun = 1'b0;
    if (valid_in) begin
      if (pair_rdy_q && !fire_held) begin
        overrun = 1'b1;
      end else begin
        accept  = 1'b1;
        state_d = (state_q == EXP_SYS) ? EXP_PAR : EXP_SYS;
      end
    end
  end

  // Pairing registers: FSM state, latched sys/par words and the held-pair flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EXP_SYS;
      sys_q      <= '0;
      par_q      <= '0;
      pair_rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && (state_q == EXP_SYS)) sys_q <= in;
      if (par_done) par_q <= in;
      if (fire) pair_rdy_q <= 1'b0;
      else if (par_done) pair_rdy_q <= 1'b1;
    end
  end

  // A-priori FIFO storage; contents are don't-care while the count is zero.
  always_ff @(posedge clk) begin
    if (push) apr_mem[wr_ptr_q] <= apriori;
  end

  // A-priori FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      apr_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      apr_cnt_q <= apr_cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Block tracking: latch the block length on the first sys of each block
  // (zero is treated as one) and advance the symbol counter on every fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_cnt_q <= '0;
      len_q     <= BLK_W'(1);
    end else begin
      if (new_block) len_q <= (blklen == '0) ? BLK_W'(1) : blklen;
      if (fire) sym_cnt_q <= sym_last ? '0 : sym_cnt_q + BLK_W'(1);
    end
  end

  // Registered outputs: metrics hold between symbols, strobes pulse on fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_branch1_t <= '0;
      init_branch2_t <= '0;
      valid_out      <= 1'b0;
      last_out       <= 1'b0;
      sym_idx        <= '0;
      err            <= '0;
    end else begin
      valid_out <= fire;
      last_out  <= fire && sym_last;
      if (fire) begin
        init_branch1_t <= sat(g1_x);
        init_branch2_t <= sat(g2_x);
        sym_idx        <= sym_cnt_q;
      end
      err <= err | {new_block && (blklen == '0), overrun, apr_ovf};
    end
  end

endmodule

// File: tb/tb_siso_branch_metric.sv
// ---------------------------------------------------------------------------
// tb_siso_branch_metric
//
// Self-checking bench for siso_branch_metric. Two instances share all inputs:
// the default configuration (OUT_W=18, lossless) and a saturating one
// (OUT_W=16). Expected symbols come from a block-level model: each symbol's
// metrics are plain integer sums clamped to the symmetric output range, and
// its index / last flag follow from the block length rules.
// ---------------------------------------------------------------------------
module tb_siso_branch_metric;

  localparam int IN_W   = 16;
  localparam int OUT_W  = 18;
  localparam int OUT_WS = 16;
  localparam int BLK_W  = 13;
`ifdef SISO_BM_TAIL_EN
  localparam int TAIL = 3;
`else
  localparam int TAIL = 0;
`endif

  typedef struct {
    int g1;
    int g2;
    int idx;
    bit last;
    int cyc;
  } obs_t;

  typedef struct {
    int g1;
    int g2;
    int g1s;
    int g2s;
    int idx;
    bit last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [IN_W-1:0]   in_w;
  logic              valid_in;
  logic [IN_W-1:0]   apriori;
  logic              valid_apriori;
  logic [BLK_W-1:0]  blklen;

  logic [OUT_W-1:0]  g1, g2;
  logic              valid_out, last_out;
  logic [BLK_W-1:0]  sym_idx;
  logic [2:0]        err;

  logic [OUT_WS-1:0] s_g1, s_g2;
  logic              s_valid, s_last;
  logic [BLK_W-1:0]  s_idx;
  logic [2:0]        s_err;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cycle   = 0;
  obs_t obs_q[$];
  obs_t sat_q[$];
  exp_t exp_q[$];
  int   m_idx = 0;
  int   m_len = 1;

  siso_branch_metric #(.IN_W(IN_W), .OUT_W(OUT_W), .APR_DEPTH(4), .BLK_W(BLK_W)) dut (
    .clk(clk), .rst(rst), .in(in_w), .valid_in(valid_in),
    .apriori(apriori), .valid_apriori(valid_apriori), .blklen(blklen),
    .init_branch1_t(g1), .init_branch2_t(g2), .valid_out(valid_out),
    .last_out(last_out), .sym_idx(sym_idx), .err(err)
  );

  siso_branch_metric #(.IN_W(IN_W), .OUT_W(OUT_WS), .APR_DEPTH(4), .BLK_W(BLK_W)) dut_sat (
    .clk(clk), .rst(rst), .in(in_w), .valid_in(valid_in),
    .apriori(apriori), .valid_apriori(valid_apriori), .blklen(blklen),
    .init_branch1_t(s_g1), .init_branch2_t(s_g2), .valid_out(s_valid),
    .last_out(s_last), .sym_idx(s_idx), .err(s_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Capture every emitted symbol of both instances, away from the clock edge.
  always @(negedge clk) begin
    obs_t o;
    if (valid_out === 1'b1) begin
      o.g1 = int'($signed(g1));
      o.g2 = int'($signed(g2));
      o.idx = int'(sym_idx);
      o.last = last_out;
      o.cyc = cycle;
      obs_q.push_back(o);
    end
    if (s_valid === 1'b1) begin
      o.g1 = int'($signed(s_g1));
      o.g2 = int'($signed(s_g2));
      o.idx = int'(s_idx);
      o.last = s_last;
      o.cyc = cycle;
      sat_q.push_back(o);
    end
  end

  function automatic int sat_f(input int v, input int w);
    int m;
    m = (1 << (w - 1)) - 1;
    if (v > m) return m;
    if (v < -m) return -m;
    return v;
  endfunction

  function automatic int rnd16();
    logic [15:0] r;
    case ($urandom_range(0, 7))
      0: r = 16'h7fff;
      1: r = 16'h8000;
      default: r = 16'($urandom);
    endcase
    return int'($signed(r));
  endfunction

  function automatic bit m_next_is_tail();
    if (m_idx == 0) return 1'b0;
    return m_idx >= m_len;
  endfunction

  // Block-level model: one expected entry per symbol, in emission order.
  function automatic void m_expect(input int s, input int p, input int a);
    exp_t e;
    int   av;
    if (m_idx == 0) m_len = (blklen == '0) ? 1 : int'(blklen);
    av = (m_idx >= m_len) ? 0 : a;
    e.g1 = sat_f(s + av + p, OUT_W);
    e.g2 = sat_f(s + av - p, OUT_W);
    e.g1s = sat_f(s + av + p, OUT_WS);
    e.g2s = sat_f(s + av - p, OUT_WS);
    e.idx = m_idx;
    e.last = (m_idx == m_len - 1 + TAIL);
    exp_q.push_back(e);
    m_idx = e.last ? 0 : m_idx + 1;
  endfunction

  task automatic step(input bit vi, input int w, input bit va, input int a);
    valid_in = vi;
    in_w = IN_W'(w);
    valid_apriori = va;
    apriori = IN_W'(a);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    valid_apriori = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 1'b0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    obs_q.delete();
    sat_q.delete();
    exp_q.delete();
    m_idx = 0;
  endtask

  task automatic send_sym(input int s, input int p, input int a);
    bit tl;
    tl = m_next_is_tail();
    m_expect(s, p, a);
    if (!tl) step(1'b0, 0, 1'b1, a);
    step(1'b1, s, 1'b0, 0);
    step(1'b1, p, 1'b0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    n_tests++;
    if (valid_out !== 1'b0 || last_out !== 1'b0 || g1 !== '0 || g2 !== '0 ||
        sym_idx !== '0 || err !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got valid=%b last=%b g1=%0h g2=%0h idx=%0d err=%b, expected all zero",
               valid_out, last_out, g1, g2, sym_idx, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_pairing();
    int kp;
    blklen = 16;
    do_reset();
    m_expect(10, 20, 5);
    step(1'b1, 10, 1'b0, 0);
    step(1'b1, 20, 1'b0, 0);
    step(1'b0, 0, 1'b1, 5);
    idle(4);
    m_expect(-7, 4, -3);
    step(1'b0, 0, 1'b1, -3);
    idle(1);
    step(1'b1, -7, 1'b0, 0);
    kp = cycle;
    step(1'b1, 4, 1'b0, 0);
    idle(3);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("[TB] FAIL pairing_count: got %0d symbols, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i].g1 !== exp_q[i].g1 || obs_q[i].g2 !== exp_q[i].g2 ||
          obs_q[i].idx !== exp_q[i].idx || obs_q[i].last !== exp_q[i].last) begin
        n_fail++;
        $display("[TB] FAIL pairing[%0d]: got g1=%0d g2=%0d idx=%0d last=%0d, expected g1=%0d g2=%0d idx=%0d last=%0d",
                 i, obs_q[i].g1, obs_q[i].g2, obs_q[i].idx, obs_q[i].last,
                 exp_q[i].g1, exp_q[i].g2, exp_q[i].idx, exp_q[i].last);
      end
    end
    if (obs_q.size() == 2) begin
      n_tests++;
      if (obs_q[1].cyc !== kp + 1) begin
        n_fail++;
        $display("[TB] FAIL early_apr_latency: got valid_out in cycle %0d, expected %0d", obs_q[1].cyc, kp + 1);
      end
    end
    n_tests++;
    if (err !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL pairing_err: got %b, expected 000", err);
    end
  endtask

  task automatic test_saturation();
    blklen = 100;
    do_reset();
    send_sym(32767, 32767, 32767);
    send_sym(-32768, -32768, -32768);
    idle(3);
    n_tests++;
    if (obs_q.size() != exp_q.size() || sat_q.size() != exp_q.size()) begin
      n_fail++;
      $display("[TB] FAIL sat_count: got %0d/%0d symbols, expected %0d", obs_q.size(), sat_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size() && i < sat_q.size(); i++) begin
      n_tests++;
      if (obs_q[i].g1 !== exp_q[i].g1 || obs_q[i].g2 !== exp_q[i].g2 ||
          sat_q[i].g1 !== exp_q[i].g1s || sat_q[i].g2 !== exp_q[i].g2s) begin
        n_fail++;
        $display("[TB] FAIL saturation[%0d]: got wide %0d/%0d narrow %0d/%0d, expected wide %0d/%0d narrow %0d/%0d",
                 i, obs_q[i].g1, obs_q[i].g2, sat_q[i].g1, sat_q[i].g2,
                 exp_q[i].g1, exp_q[i].g2, exp_q[i].g1s, exp_q[i].g2s);
      end
    end
  endtask

  task automatic test_block_last();
    blklen = 4;
    do_reset();
    for (int i = 0; i < 2 * (4 + TAIL); i++) send_sym(rnd16(), rnd16(), rnd16());
    idle(3);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("[TB] FAIL block_count: got %0d symbols, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i].g1 !== exp_q[i].g1 || obs_q[i].g2 !== exp_q[i].g2 ||
          obs_q[i].idx !== exp_q[i].idx || obs_q[i].last !== exp_q[i].last) begin
        n_fail++;
        $display("[TB] FAIL block[%0d]: got g1=%0d g2=%0d idx=%0d last=%0d, expected g1=%0d g2=%0d idx=%0d last=%0d",
                 i, obs_q[i].g1, obs_q[i].g2, obs_q[i].idx, obs_q[i].last,
                 exp_q[i].g1, exp_q[i].g2, exp_q[i].idx, exp_q[i].last);
      end
    end
  endtask

  task automatic test_fifo_overrun();
    int a[5];
    int s, p;
    blklen = 100;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      a[i] = rnd16();
      step(1'b0, 0, 1'b1, a[i]);
    end
    n_tests++;
    if (err !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL apr_overflow_err: got %b, expected 001", err);
    end
    for (int i = 0; i < 4; i++) begin
      s = rnd16();
      p = rnd16();
      m_expect(s, p, a[i]);
      step(1'b1, s, 1'b0, 0);
      step(1'b1, p, 1'b0, 0);
    end
    s = rnd16();
    p = rnd16();
    step(1'b1, s, 1'b0, 0);
    step(1'b1, p, 1'b0, 0);
    step(1'b1, rnd16(), 1'b0, 0);
    idle(2);
    n_tests++;
    if (err !== 3'b011 || obs_q.size() != 4) begin
      n_fail++;
      $display("[TB] FAIL pair_overrun: got err=%b symbols=%0d, expected err=011 symbols=4", err, obs_q.size());
    end
    a[4] = rnd16();
    m_expect(s, p, a[4]);
    step(1'b0, 0, 1'b1, a[4]);
    idle(3);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("[TB] FAIL fifo_count: got %0d symbols, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i].g1 !== exp_q[i].g1 || obs_q[i].g2 !== exp_q[i].g2 || obs_q[i].idx !== exp_q[i].idx) begin
        n_fail++;
        $display("[TB] FAIL fifo_order[%0d]: got g1=%0d g2=%0d idx=%0d, expected g1=%0d g2=%0d idx=%0d",
                 i, obs_q[i].g1, obs_q[i].g2, obs_q[i].idx, exp_q[i].g1, exp_q[i].g2, exp_q[i].idx);
      end
    end
  endtask

  task automatic test_reset_midblock();
    int s, p, a;
    blklen = 8;
    do_reset();
    send_sym(rnd16(), rnd16(), rnd16());
    send_sym(rnd16(), rnd16(), rnd16());
    step(1'b0, 0, 1'b1, rnd16());
    step(1'b0, 0, 1'b1, rnd16());
    step(1'b1, rnd16(), 1'b0, 0);
    n_tests++;
    if (obs_q.size() != 2) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_count: got %0d symbols, expected 2", obs_q.size());
    end
    do_reset();
    idle(3);
    n_tests++;
    if (obs_q.size() != 0 || err !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL stale_after_reset: got symbols=%0d err=%b, expected symbols=0 err=000", obs_q.size(), err);
    end
    s = rnd16();
    p = rnd16();
    a = rnd16();
    m_expect(s, p, a);
    step(1'b1, s, 1'b0, 0);
    step(1'b1, p, 1'b0, 0);
    idle(2);
    step(1'b0, 0, 1'b1, a);
    idle(3);
    n_tests++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL post_reset_count: got %0d symbols, expected 1", obs_q.size());
    end else if (obs_q[0].g1 !== exp_q[0].g1 || obs_q[0].g2 !== exp_q[0].g2 || obs_q[0].idx !== 0) begin
      n_fail++;
      $display("[TB] FAIL post_reset_sym: got g1=%0d g2=%0d idx=%0d, expected g1=%0d g2=%0d idx=0",
               obs_q[0].g1, obs_q[0].g2, obs_q[0].idx, exp_q[0].g1, exp_q[0].g2);
    end
    blklen = 0;
    do_reset();
    for (int i = 0; i < 2 * (1 + TAIL); i++) send_sym(rnd16(), rnd16(), rnd16());
    idle(3);
    n_tests++;
    if (err !== 3'b100 || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("[TB] FAIL blklen_zero: got err=%b symbols=%0d, expected err=100 symbols=%0d",
               err, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i].idx !== exp_q[i].idx || obs_q[i].last !== exp_q[i].last || obs_q[i].g1 !== exp_q[i].g1) begin
        n_fail++;
        $display("[TB] FAIL blklen_zero[%0d]: got idx=%0d last=%0d g1=%0d, expected idx=%0d last=%0d g1=%0d",
                 i, obs_q[i].idx, obs_q[i].last, obs_q[i].g1, exp_q[i].idx, exp_q[i].last, exp_q[i].g1);
      end
    end
  endtask

  // Randomised back-to-back traffic: a-priori arrives before or after its pair
  // with random gaps, over several blocks of random length.
  task automatic test_back_to_back();
    int s, p, a, d, nsym;
    do_reset();
    for (int b = 0; b < 4; b++) begin
      blklen = BLK_W'($urandom_range(1, 6));
      nsym = int'(blklen) + TAIL;
      for (int k = 0; k < nsym; k++) begin
        s = rnd16();
        p = rnd16();
        a = rnd16();
        if (m_next_is_tail()) begin
          m_expect(s, p, a);
          step(1'b1, s, 1'b0, 0);
          idle($urandom_range(0, 2));
          step(1'b1, p, 1'b0, 0);
        end else if ($urandom_range(0, 1) == 0) begin
          m_expect(s, p, a);
          step(1'b0, 0, 1'b1, a);
          idle($urandom_range(0, 1));
          step(1'b1, s, 1'b0, 0);
          idle($urandom_range(0, 2));
          step(1'b1, p, 1'b0, 0);
        end else begin
          m_expect(s, p, a);
          step(1'b1, s, 1'b0, 0);
          idle($urandom_range(0, 2));
          d = $urandom_range(0, 2);
          if (d == 0) begin
            step(1'b1, p, 1'b1, a);
          end else begin
            step(1'b1, p, 1'b0, 0);
            idle(d - 1);
            step(1'b0, 0, 1'b1, a);
          end
          idle(1);
        end
        idle($urandom_range(0, 1));
      end
    end
    idle(4);
    n_tests++;
    if (obs_q.size() != exp_q.size() || sat_q.size() != exp_q.size() || err !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL random_count: got %0d/%0d symbols err=%b, expected %0d symbols err=000",
               obs_q.size(), sat_q.size(), err, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size() && i < sat_q.size(); i++) begin
      n_tests++;
      if (obs_q[i].g1 !== exp_q[i].g1 || obs_q[i].g2 !== exp_q[i].g2 ||
          obs_q[i].idx !== exp_q[i].idx || obs_q[i].last !== exp_q[i].last ||
          sat_q[i].g1 !== exp_q[i].g1s || sat_q[i].g2 !== exp_q[i].g2s) begin
        n_fail++;
        $display("[TB] FAIL random[%0d]: got g1=%0d g2=%0d idx=%0d last=%0d sat=%0d/%0d, expected g1=%0d g2=%0d idx=%0d last=%0d sat=%0d/%0d",
                 i, obs_q[i].g1, obs_q[i].g2, obs_q[i].idx, obs_q[i].last, sat_q[i].g1, sat_q[i].g2,
                 exp_q[i].g1, exp_q[i].g2, exp_q[i].idx, exp_q[i].last, exp_q[i].g1s, exp_q[i].g2s);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_w = '0;
    valid_in = 1'b0;
    apriori = '0;
    valid_apriori = 1'b0;
    blklen = '0;
    #1;
    test_reset();
    test_pairing();
    test_saturation();
    test_block_last();
    test_fifo_overrun();
    test_reset_midblock();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
